// File: rtl/case_2_acc_pkg.sv
// Shared types and narrowing helpers for the case_2 product accumulator.
// Saturating narrowing is selected with CASE_2_ACC_SAT_EN.
package case_2_acc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  localparam int BLOCK_LEN_DEF = 4;

  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  localparam int CNT_W = cnt_w(BLOCK_LEN_DEF);

  function automatic logic fits(
    input logic signed [63:0] v,
    input int                 w
  );
    logic signed [63:0] lo;
    logic signed [63:0] hi;
    lo = -(64'sd1 <<< (w - 1));
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    return (v >= lo) && (v <= hi);
  endfunction

  function automatic logic signed [63:0] clamp(
    input logic signed [63:0] v,
    input int                 w
  );
    logic signed [63:0] lo;
    logic signed [63:0] hi;
    lo = -(64'sd1 <<< (w - 1));
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/case_2_prod_accum_6s_if.sv
// Product-in / block-result-out handshake bundle.
// master = upstream/downstream side, slave = accumulator.
interface case_2_prod_accum_6s_if #(
  parameter int DIN_WIDTH  = 6,
  parameter int DOUT_WIDTH = 6
);
  logic                         flush;
  logic signed [DIN_WIDTH-1:0]  in_data;
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DOUT_WIDTH-1:0] out_data;
  logic                         out_ovf;
  logic                         out_valid;
  logic                         out_ready;

  modport master (
    output flush,
    output in_data,
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out_data,
    input  out_ovf,
    input  out_valid
  );

  modport slave (
    input  flush,
    input  in_data,
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out_data,
    output out_ovf,
    output out_valid
  );
endinterface

// File: rtl/case_2_acc_narrow.sv
// Shift, narrow (wrap, or clamp with CASE_2_ACC_SAT_EN) and overflow detect.
// Purely combinational; feeds the result registers.
module case_2_acc_narrow
  import case_2_acc_pkg::*;
#(
  parameter int ACC_WIDTH  = 12,
  parameter int DOUT_WIDTH = 6,
  parameter int SHIFT      = 0
) (
  input  logic signed [ACC_WIDTH-1:0]  sum,
  output logic signed [DOUT_WIDTH-1:0] dout,
  output logic                         ovf
);

  logic signed [ACC_WIDTH-1:0] s;
  logic signed [63:0]          s64;

  assign s   = sum >>> SHIFT;
  assign s64 = 64'(s);
  assign ovf = ~fits(s64, DOUT_WIDTH);

`ifdef CASE_2_ACC_SAT_EN
  assign dout = DOUT_WIDTH'(clamp(s64, DOUT_WIDTH));
`else
  assign dout = s[DOUT_WIDTH-1:0];
`endif

endmodule

// File: rtl/case_2_prod_accum_6s.sv
// Block accumulator for case_2 6s products: BLOCK_LEN sums per result.
// CASE_2_ACC_SAT_EN selects clamping instead of wrapping on narrowing.
module case_2_prod_accum_6s
  import case_2_acc_pkg::*;
#(
  parameter int DIN_WIDTH  = 6,
  parameter int ACC_WIDTH  = 12,
  parameter int DOUT_WIDTH = 6,
  parameter int BLOCK_LEN  = 4,
  parameter int SHIFT      = 0
) (
  input logic                  ap_clk,
  input logic                  ap_rst,
  case_2_prod_accum_6s_if.slave bus
);

  localparam int CW = cnt_w(BLOCK_LEN);

  state_t                         state;
  state_t                         nxt;
  logic signed [ACC_WIDTH-1:0]    acc;
  logic [CW-1:0]                  cnt;
  logic signed [DOUT_WIDTH-1:0]   dout_q;
  logic                           ovf_q;

  logic                           busy;
  logic                           in_rdy;
  logic                           accept;
  logic                           last;
  logic [CW-1:0]                  cnt_inc;
  logic signed [ACC_WIDTH-1:0]    din_x;
  logic signed [ACC_WIDTH-1:0]    base;
  logic signed [ACC_WIDTH-1:0]    sum_nxt;
  logic signed [DOUT_WIDTH-1:0]   n_dout;
  logic                           n_ovf;

  assign busy    = (state == DONE);
  assign in_rdy  = ~ap_rst & ~busy;
  assign accept  = bus.in_valid & in_rdy & ~bus.flush;
  assign din_x   = ACC_WIDTH'(bus.in_data);
  assign base    = (state == IDLE) ? '0 : acc;
  assign sum_nxt = base + din_x;
  assign cnt_inc = ((state == IDLE) ? '0 : cnt) + CW'(1);
  assign last    = (cnt_inc == CW'(BLOCK_LEN));

  case_2_acc_narrow #(
    .ACC_WIDTH (ACC_WIDTH),
    .DOUT_WIDTH(DOUT_WIDTH),
    .SHIFT     (SHIFT)
  ) u_narrow (
    .sum (sum_nxt),
    .dout(n_dout),
    .ovf (n_ovf)
  );

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE, ACCUM: begin
        if (bus.flush) nxt = IDLE;
        else if (accept) nxt = last ? DONE : ACCUM;
      end
      DONE: begin
        if (bus.out_ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state  <= IDLE;
      acc    <= '0;
      cnt    <= '0;
      dout_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      state <= nxt;
      if (!busy && bus.flush) begin
        acc <= '0;
        cnt <= '0;
      end else if (accept) begin
        acc <= sum_nxt;
        cnt <= cnt_inc;
        // Result regs capture the final sum on entry to DONE
        if (last) begin
          dout_q <= n_dout;
          ovf_q  <= n_ovf;
        end
      end else if (busy && bus.out_ready) begin
        acc <= '0;
        cnt <= '0;
      end
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = busy;
  assign bus.out_data  = dout_q;
  assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_case_2_prod_accum_6s.sv
// Directed + scoreboard bench for case_2_prod_accum_6s.
// Expected results follow the CASE_2_ACC_SAT_EN build setting.
module tb_case_2_prod_accum_6s;

  typedef struct {
    int data;
    int ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   msum = 0;
  int   mcnt = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  case_2_prod_accum_6s_if #(.DIN_WIDTH(6), .DOUT_WIDTH(6)) bus ();

  case_2_prod_accum_6s dut (
    .ap_clk(clk),
    .ap_rst(rst),
    .bus   (bus)
  );

  function automatic exp_t model(input int s);
    exp_t e;
    logic [31:0] v;
    e.ovf = (s > 31 || s < -32) ? 1 : 0;
`ifdef CASE_2_ACC_SAT_EN
    e.data = (s > 31) ? 31 : ((s < -32) ? -32 : s);
`else
    v = s;
    e.data = v[5] ? (int'(v[5:0]) - 64) : int'(v[5:0]);
`endif
    return e;
  endfunction

  task automatic chk(input string tag,
                     input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int v);
    int n;
    n = 0;
    @(negedge clk);
    bus.in_data  = 6'(v);
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) begin
      total++;
      bad++;
      $error("FAIL push_timeout observed=0 expected=1");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    msum += v;
    mcnt++;
    if (mcnt == 4) begin
      q.push_back(model(msum));
      msum = 0;
      mcnt = 0;
      chk("latency_valid", {31'd0, bus.out_valid}, 1);
    end else begin
      chk("mid_block_valid", {31'd0, bus.out_valid}, 0);
    end
  endtask

  task automatic take(input string tag);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20 || q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s_no_result observed=%0d expected=1", tag, q.size());
    end else begin
      e = q.pop_front();
      chk({tag, "_data"}, bus.out_data, e.data);
      chk({tag, "_ovf"}, {31'd0, bus.out_ovf}, e.ovf);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      chk({tag, "_valid_drop"}, {31'd0, bus.out_valid}, 0);
    end
  endtask

  task automatic blk(input int a, input int b, input int c, input int d);
    push(a);
    push(b);
    push(c);
    push(d);
  endtask

  initial begin
    bus.flush     = 1'b0;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    // reset state
    #12;
    chk("rst_valid", {31'd0, bus.out_valid}, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_ovf", {31'd0, bus.out_ovf}, 0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", {31'd0, bus.in_ready}, 1);

    // basic sum
    blk(1, 2, 3, 4);
    take("sum10");

    // positive / negative overflow
    blk(31, 31, 31, 31);
    take("pos_ovf");
    blk(-32, -32, -32, -32);
    take("neg_ovf");

    // flush drops partial sum and same-cycle input
    push(5);
    push(5);
    @(negedge clk);
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 6'sd9;
    @(posedge clk);
    #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    msum = 0;
    mcnt = 0;
    blk(1, 1, 1, 1);
    take("flush");

    // result held while out_ready=0; pending input not consumed
    blk(3, -7, 2, 1);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 6'sd7;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("hold_in_ready", {31'd0, bus.in_ready}, 0);
      chk("hold_valid", {31'd0, bus.out_valid}, 1);
      chk("hold_data", bus.out_data, q[0].data);
    end
    take("hold");
    chk("post_hs_in_ready", {31'd0, bus.in_ready}, 1);
    blk(7, 1, 1, 1);
    take("after_hold");

    // async reset mid-block
    push(9);
    push(-4);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, bus.out_valid}, 0);
    chk("mid_rst_data", bus.out_data, 0);
    chk("mid_rst_ovf", {31'd0, bus.out_ovf}, 0);
    chk("mid_rst_in_ready", {31'd0, bus.in_ready}, 0);
    msum = 0;
    mcnt = 0;
    @(negedge clk);
    rst = 1'b0;
    blk(2, 2, 2, 2);
    take("after_rst");

    // random blocks
    for (int k = 0; k < 6; k++) begin
      blk(int'($urandom_range(0, 63)) - 32, int'($urandom_range(0, 63)) - 32,
          int'($urandom_range(0, 63)) - 32, int'($urandom_range(0, 63)) - 32);
      take("rand");
    end

    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
